// File: rtl/musa_if_pkg.sv
// MUSA IF-stage shared constants and PC sequencer state encoding.
// Latency: n/a (declarations only).  Backpressure: n/a.
package musa_if_pkg;

    localparam int MUSA_AW           = 32;
    localparam int MUSA_DW           = 32;
    localparam int MUSA_RESET_VECTOR = 0;
    localparam int MUSA_TRAP_VECTOR  = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_KILL   = 2'd2,
        ST_HALTED = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_incr.sv
// Word-address incrementer feeding the link value and the sequential PC update.
// Latency: combinational.  Backpressure: none; wraps silently at 2^AW-1.
module pc_incr #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc_in,
    output logic [AW-1:0] pc_inc
);

    assign pc_inc = pc_in + {{(AW-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC owner: issues req/ack fetches, sequences redirect/halt, feeds IF/ID via a 1-entry skid.
// Latency: 1 cycle imemAck -> instValid.  Backpressure: stall holds output, parks one instr in skid, gates new requests.
// Optional trap entry (trapReq/epc) is built only when MUSA_PC_TRAP_EN is defined.
module pc_sequencer
    import musa_if_pkg::*;
#(
    parameter int            AW           = MUSA_AW,
    parameter int            DW           = MUSA_DW,
    parameter logic [AW-1:0] RESET_VECTOR = AW'(MUSA_RESET_VECTOR)
`ifdef MUSA_PC_TRAP_EN
    ,
    parameter logic [AW-1:0] TRAP_VECTOR  = AW'(MUSA_TRAP_VECTOR)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          halt,
    input  logic          redirectValid,
    input  logic [AW-1:0] redirectTarget,
    output logic          imemReq,
    output logic [AW-1:0] imemAddr,
    input  logic          imemAck,
    input  logic [DW-1:0] imemData,
    output logic          instValid,
    output logic [DW-1:0] instOut,
    output logic [AW-1:0] instPc,
    output logic [AW-1:0] pcNext
`ifdef MUSA_PC_TRAP_EN
    ,
    input  logic          trapReq,
    output logic [AW-1:0] epc
`endif
);

    pc_state_e     state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pc_inc;

    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_dat_q, out_dat_d;
    logic [AW-1:0] out_pc_q, out_pc_d;
    logic          skid_vld_q, skid_vld_d;
    logic [DW-1:0] skid_dat_q, skid_dat_d;
    logic [AW-1:0] skid_pc_q, skid_pc_d;

    logic          redir_vld;
    logic [AW-1:0] redir_tgt;
    logic          req_acked;

    pc_incr #(.AW(AW)) u_pc_incr (
        .pc_in  (pc_q),
        .pc_inc (pc_inc)
    );

`ifdef MUSA_PC_TRAP_EN
    logic [AW-1:0] epc_q, epc_d;

    // A trap is just a redirect to the trap vector that also captures the faulting PC.
    assign redir_vld = trapReq | redirectValid;
    assign redir_tgt = trapReq ? TRAP_VECTOR : redirectTarget;

    always_comb begin
        epc_d = epc_q;
        if (trapReq) begin
            epc_d = out_vld_q ? out_pc_q : pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc = epc_q;
`else
    assign redir_vld = redirectValid;
    assign redir_tgt = redirectTarget;
`endif

    // A full skid means the instruction has nowhere to land, so no request goes out.
    assign imemReq   = (state_q == ST_KILL) || ((state_q == ST_REQ) && !skid_vld_q);
    assign imemAddr  = addr_q;
    assign req_acked = imemReq && imemAck;
    assign pcNext    = pc_inc;
    assign instValid = out_vld_q;
    assign instOut   = out_dat_q;
    assign instPc    = out_pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE:   state_d = halt ? ST_HALTED : ST_REQ;
            ST_REQ: begin
                if (req_acked) begin
                    pc_d = pc_inc;
                    if (halt) begin
                        state_d = ST_HALTED;
                    end
                end else if (!imemReq && halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_KILL: begin
                if (imemAck) begin
                    state_d = ST_REQ;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (redir_vld) begin
            pc_d    = redir_tgt;
            state_d = (imemReq && !imemAck) ? ST_KILL : ST_REQ;
        end
        // The wrong-path request keeps its address until memory retires it.
        addr_d = (state_d == ST_KILL) ? addr_q : pc_d;
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_pc_d   = out_pc_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        skid_pc_d  = skid_pc_q;
        if (redir_vld) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (!stall) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                out_pc_d   = skid_pc_q;
                skid_vld_d = 1'b0;
            end
        end else if (req_acked && (state_q == ST_REQ)) begin
            if (!out_vld_q || !stall) begin
                out_vld_d = 1'b1;
                out_dat_d = imemData;
                out_pc_d  = addr_q;
            end else begin
                skid_vld_d = 1'b1;
                skid_dat_d = imemData;
                skid_pc_d  = addr_q;
            end
        end else if (!stall) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_pc_q   <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            skid_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_pc_q   <= out_pc_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_pc_q  <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetches are scoreboarded at ack and checked when ID accepts them.
// Trap scenario runs only when MUSA_PC_TRAP_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instValid;
    logic [31:0] instOut;
    logic [31:0] instPc;
    logic [31:0] pcNext;
`ifdef MUSA_PC_TRAP_EN
    logic        trapReq;
    logic [31:0] epc;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    logic kill_pend;
    int   tests;
    int   fails;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .halt           (halt),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemAck        (imemAck),
        .imemData       (imemData),
        .instValid      (instValid),
        .instOut        (instOut),
        .instPc         (instPc),
        .pcNext         (pcNext)
`ifdef MUSA_PC_TRAP_EN
        ,
        .trapReq        (trapReq),
        .epc            (epc)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input logic ack, input logic stl, input logic hlt,
                       input logic rv, input logic [31:0] rt, input logic tr = 1'b0);
        logic rvx;
        exp_t e;
        rvx            = rv | tr;
        stall          = stl;
        halt           = hlt;
        redirectValid  = rv;
        redirectTarget = rt;
`ifdef MUSA_PC_TRAP_EN
        trapReq        = tr;
`endif
        imemAck        = ack & imemReq;
        imemData       = imemAddr ^ 32'h0000_00A5;
        if (!rvx && instValid && !stl) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected: observed instPc %0h, expected no instruction", instPc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", {32'h0, instPc}, {32'h0, e.pc});
                chk("sb_dat", {32'h0, instOut}, {32'h0, e.dat});
            end
        end
        if (rvx) begin
            exp_q.delete();
            kill_pend = imemReq && !imemAck;
        end else if (imemAck) begin
            if (kill_pend) begin
                kill_pend = 1'b0;
            end else begin
                exp_q.push_back('{pc: imemAddr, dat: imemData});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        tests          = 0;
        fails          = 0;
        kill_pend      = 1'b0;
        rst            = 1'b1;
        stall          = 1'b0;
        halt           = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = '0;
        imemAck        = 1'b0;
        imemData       = '0;
`ifdef MUSA_PC_TRAP_EN
        trapReq        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_req",    imemReq,   1'b0);
        chk("rst_addr",   imemAddr,  32'h0);
        chk("rst_vld",    instValid, 1'b0);
        chk("rst_out",    instOut,   32'h0);
        chk("rst_pc",     instPc,    32'h0);
        chk("rst_pcnext", pcNext,    32'h1);
`ifdef MUSA_PC_TRAP_EN
        chk("rst_epc",    epc,       32'h0);
`endif

        // 1: streaming fetch, ack every request
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_req",  imemReq,  1'b1);
            chk("t1_addr", imemAddr, 64'(i));
            cyc(1, 0, 0, 0, 0);
        end
        chk("t1_vld", instValid, 1'b1);

        // 2: stall with ack arriving -> skid, request gated
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t2_pc5", instPc, 32'h5);
        chk("t2_addr6", imemAddr, 32'h6);
        cyc(1, 1, 0, 0, 0);
        chk("t2_hold_pc", instPc, 32'h5);
        chk("t2_req_off", imemReq, 1'b0);
        cyc(0, 1, 0, 0, 0);
        chk("t2_hold_vld", instValid, 1'b1);
        cyc(0, 1, 0, 0, 0);
        chk("t2_hold_pc2", instPc, 32'h5);
        chk("t2_req_off2", imemReq, 1'b0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_drain_pc", instPc, 32'h6);
        chk("t2_req_on", imemReq, 1'b1);
        chk("t2_addr7", imemAddr, 32'h7);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // 3: redirect while addr 9 outstanding -> kill
        chk("t3_addr9", imemAddr, 32'h9);
        cyc(0, 0, 0, 1, 32'h40);
        chk("t3_kill_req", imemReq, 1'b1);
        chk("t3_kill_addr", imemAddr, 32'h9);
        chk("t3_kill_vld", instValid, 1'b0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t3_tgt_addr", imemAddr, 32'h40);
        chk("t3_tgt_vld", instValid, 1'b0);
        cyc(1, 0, 0, 0, 0);
        chk("t3_tgt_pc", instPc, 32'h40);
        cyc(0, 0, 0, 0, 0);

        // 4: redirect in the same cycle as an ack
        cyc(1, 0, 0, 1, 32'h3);
        chk("t4_addr3", imemAddr, 32'h3);
        cyc(1, 0, 0, 1, 32'h80);
        chk("t4_addr80", imemAddr, 32'h80);
        chk("t4_vld0", instValid, 1'b0);
        cyc(1, 0, 0, 0, 0);
        chk("t4_pc80", instPc, 32'h80);
        cyc(0, 0, 0, 0, 0);

        // 5: wrap, halt, resume by redirect
        cyc(1, 0, 0, 1, 32'hFFFF_FFFF);
        chk("t5_addr_max", imemAddr, 32'hFFFF_FFFF);
        chk("t5_pcnext_wrap", pcNext, 32'h0);
        cyc(1, 0, 0, 0, 0);
        chk("t5_addr_wrap", imemAddr, 32'h0);
        cyc(0, 0, 1, 0, 0);
        chk("t5_halt_req_held", imemReq, 1'b1);
        cyc(1, 0, 1, 0, 0);
        chk("t5_halted_req", imemReq, 1'b0);
        chk("t5_halted_vld", instValid, 1'b1);
        cyc(0, 0, 1, 0, 0);
        chk("t5_halted_req2", imemReq, 1'b0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_halted_req3", imemReq, 1'b0);
        chk("t5_halted_vld0", instValid, 1'b0);
        cyc(0, 0, 0, 1, 32'h10);
        chk("t5_resume_req", imemReq, 1'b1);
        chk("t5_resume_addr", imemAddr, 32'h10);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_drained", 64'(exp_q.size()), 64'h0);

`ifdef MUSA_PC_TRAP_EN
        // 6: trap wins over a simultaneous redirect
        cyc(1, 0, 0, 1, 32'h7);
        cyc(1, 0, 0, 0, 0);
        chk("t6_pc7", instPc, 32'h7);
        cyc(1, 1, 0, 1, 32'h20, 1'b1);
        chk("t6_trap_addr", imemAddr, 32'h1);
        chk("t6_epc", epc, 32'h7);
        chk("t6_vld0", instValid, 1'b0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
`endif

        // Reset in the middle of an outstanding request
        chk("rst_mid_req_before", imemReq, 1'b1);
        rst           = 1'b1;
        imemAck       = 1'b0;
        stall         = 1'b0;
        halt          = 1'b0;
        redirectValid = 1'b0;
        @(negedge clk);
        chk("rst2_req",  imemReq,   1'b0);
        chk("rst2_addr", imemAddr,  32'h0);
        chk("rst2_vld",  instValid, 1'b0);
        chk("rst2_out",  instOut,   32'h0);
        chk("rst2_pc",   instPc,    32'h0);
`ifdef MUSA_PC_TRAP_EN
        chk("rst2_epc",  epc,       32'h0);
`endif
        rst = 1'b0;
        exp_q.delete();
        kill_pend = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("rst2_first_req", imemReq, 1'b1);
        chk("rst2_first_addr", imemAddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
